// File: rtl/i281_isa_pkg.sv
// i281 ISA constants shared by the instruction encoder and the program loader.
// Holds the mnemonic codes, opcodes, sub-op codes, field positions and loader states.
package i281_isa_pkg;

  typedef enum logic [4:0] {
    MN_NOOP    = 5'd0,
    MN_INPUTC  = 5'd1,
    MN_INPUTCF = 5'd2,
    MN_INPUTD  = 5'd3,
    MN_INPUTDF = 5'd4,
    MN_MOVE    = 5'd5,
    MN_LOADI   = 5'd6,
    MN_ADD     = 5'd7,
    MN_ADDI    = 5'd8,
    MN_SUB     = 5'd9,
    MN_SUBI    = 5'd10,
    MN_LOAD    = 5'd11,
    MN_LOADF   = 5'd12,
    MN_STORE   = 5'd13,
    MN_STOREF  = 5'd14,
    MN_SHIFTL  = 5'd15,
    MN_SHIFTR  = 5'd16,
    MN_CMP     = 5'd17,
    MN_JUMP    = 5'd18,
    MN_BRE     = 5'd19,
    MN_BRNE    = 5'd20,
    MN_BRG     = 5'd21,
    MN_BRGE    = 5'd22
  } mnem_e;

  localparam logic [3:0] OPC_NOOP   = 4'h0;
  localparam logic [3:0] OPC_INPUT  = 4'h1;
  localparam logic [3:0] OPC_MOVE   = 4'h2;
  localparam logic [3:0] OPC_LOADI  = 4'h3;
  localparam logic [3:0] OPC_ADD    = 4'h4;
  localparam logic [3:0] OPC_ADDI   = 4'h5;
  localparam logic [3:0] OPC_SUB    = 4'h6;
  localparam logic [3:0] OPC_SUBI   = 4'h7;
  localparam logic [3:0] OPC_LOAD   = 4'h8;
  localparam logic [3:0] OPC_LOADF  = 4'h9;
  localparam logic [3:0] OPC_STORE  = 4'hA;
  localparam logic [3:0] OPC_STOREF = 4'hB;
  localparam logic [3:0] OPC_SHIFT  = 4'hC;
  localparam logic [3:0] OPC_CMP    = 4'hD;
  localparam logic [3:0] OPC_JUMP   = 4'hE;
  localparam logic [3:0] OPC_BRANCH = 4'hF;

  // Sub-op codes occupy the Y field for the input, shift and branch classes
  localparam logic [1:0] SUB_INPUTC  = 2'b00;
  localparam logic [1:0] SUB_INPUTCF = 2'b01;
  localparam logic [1:0] SUB_INPUTD  = 2'b10;
  localparam logic [1:0] SUB_INPUTDF = 2'b11;
  localparam logic [1:0] SUB_SHIFTL  = 2'b00;
  localparam logic [1:0] SUB_SHIFTR  = 2'b01;
  localparam logic [1:0] SUB_BRE     = 2'b00;
  localparam logic [1:0] SUB_BRNE    = 2'b01;
  localparam logic [1:0] SUB_BRG     = 2'b10;
  localparam logic [1:0] SUB_BRGE    = 2'b11;
  localparam logic [1:0] REG_NONE    = 2'b00;
  localparam logic [7:0] IMM_NONE    = 8'h00;

  localparam int OPC_LSB = 12;
  localparam int X_LSB   = 10;
  localparam int Y_LSB   = 8;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } ld_state_e;

  function automatic logic [15:0] pack_word(input logic [3:0] opc, input logic [1:0] x,
                                            input logic [1:0] y, input logic [7:0] imm);
    logic [15:0] w;
    w = '0;
    w[OPC_LSB +: 4] = opc;
    w[X_LSB +: 2]   = x;
    w[Y_LSB +: 2]   = y;
    w[IMM_LSB +: 8] = imm;
    return w;
  endfunction

endpackage

// File: rtl/i281_instr_field_encoder.sv
// Combinational encoder: symbolic i281 instruction fields to a 16-bit word.
// Codes above BRGE report legal=0 and produce a zero word.
module i281_instr_field_encoder
  import i281_isa_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [1:0]  x,
  input  logic [1:0]  y,
  input  logic [7:0]  imm,
  output logic [15:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (mnem)
      MN_NOOP:    word = '0;
      MN_INPUTC:  word = pack_word(OPC_INPUT, x, SUB_INPUTC, imm);
      MN_INPUTCF: word = pack_word(OPC_INPUT, x, SUB_INPUTCF, imm);
      MN_INPUTD:  word = pack_word(OPC_INPUT, x, SUB_INPUTD, imm);
      MN_INPUTDF: word = pack_word(OPC_INPUT, x, SUB_INPUTDF, imm);
      MN_MOVE:    word = pack_word(OPC_MOVE, x, y, IMM_NONE);
      MN_ADD:     word = pack_word(OPC_ADD, x, y, IMM_NONE);
      MN_SUB:     word = pack_word(OPC_SUB, x, y, IMM_NONE);
      MN_CMP:     word = pack_word(OPC_CMP, x, y, IMM_NONE);
      MN_LOADI:   word = pack_word(OPC_LOADI, x, REG_NONE, imm);
      MN_ADDI:    word = pack_word(OPC_ADDI, x, REG_NONE, imm);
      MN_SUBI:    word = pack_word(OPC_SUBI, x, REG_NONE, imm);
      MN_LOAD:    word = pack_word(OPC_LOAD, x, REG_NONE, imm);
      MN_STORE:   word = pack_word(OPC_STORE, x, REG_NONE, imm);
      MN_LOADF:   word = pack_word(OPC_LOADF, x, y, imm);
      MN_STOREF:  word = pack_word(OPC_STOREF, x, y, imm);
      MN_SHIFTL:  word = pack_word(OPC_SHIFT, x, SUB_SHIFTL, IMM_NONE);
      MN_SHIFTR:  word = pack_word(OPC_SHIFT, x, SUB_SHIFTR, IMM_NONE);
      MN_JUMP:    word = pack_word(OPC_JUMP, REG_NONE, REG_NONE, imm);
      MN_BRE:     word = pack_word(OPC_BRANCH, REG_NONE, SUB_BRE, imm);
      MN_BRNE:    word = pack_word(OPC_BRANCH, REG_NONE, SUB_BRNE, imm);
      MN_BRG:     word = pack_word(OPC_BRANCH, REG_NONE, SUB_BRG, imm);
      MN_BRGE:    word = pack_word(OPC_BRANCH, REG_NONE, SUB_BRGE, imm);
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/i281_instr_encoder_loader.sv
// Program loader: encodes a stream of symbolic instructions and writes them to
// instruction memory from address 0 upward, one word per two cycles at most.
//   state  | meaning
//   IDLE   | after reset, waiting for Start
//   ACCEPT | In_Ready=1, waiting for an instruction
//   WRITE  | one-cycle memory write of the registered word
//   DONE   | session finished (last instruction or memory full)
//   ERROR  | illegal mnemonic received, nothing further written
module i281_instr_encoder_loader
  import i281_isa_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [4:0]        In_Mnem,
  input  logic [1:0]        In_X,
  input  logic [1:0]        In_Y,
  input  logic [7:0]        In_Imm,
  input  logic              In_Last,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [15:0]       Mem_Data,
  output logic [ADDR_W:0]   Words_Written,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

  ld_state_e         state, next_state;
  logic [15:0]       enc_word;
  logic              enc_legal;
  logic              last_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_inc;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic              start_ok;
  logic              accept;

  i281_instr_field_encoder u_enc (
    .mnem  (In_Mnem),
    .x     (In_X),
    .y     (In_Y),
    .imm   (In_Imm),
    .word  (enc_word),
    .legal (enc_legal)
  );

  assign count_inc = count_q + CNT_ONE;
  assign start_ok  = Start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign accept    = (state == ST_ACCEPT) && In_Valid;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    In_Ready   = 1'b0;
    Mem_WE     = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    Error      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) next_state = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        In_Ready = 1'b1;
        Busy     = 1'b1;
        if (accept) next_state = enc_legal ? ST_WRITE : ST_ERROR;
      end
      ST_WRITE: begin
        Mem_WE = 1'b1;
        Busy   = 1'b1;
        // memory-full terminates the session even without In_Last, so no wrap
        if (last_q || count_inc == DEPTH_CNT) next_state = ST_DONE;
        else                                  next_state = ST_ACCEPT;
      end
      ST_DONE: begin
        Done = 1'b1;
        if (start_ok) next_state = ST_ACCEPT;
      end
      ST_ERROR: begin
        Error = 1'b1;
        if (start_ok) next_state = ST_ACCEPT;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Address and data are captured at the handshake so they are stable during
  // WRITE and simply hold afterwards.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      if (start_ok) begin
        count_q <= '0;
        addr_q  <= '0;
      end
      if (accept && enc_legal) begin
        data_q <= enc_word;
        addr_q <= count_q[ADDR_W-1:0];
        last_q <= In_Last;
      end
      if (state == ST_WRITE) count_q <= count_inc;
    end
  end

  assign Mem_Addr      = addr_q;
  assign Mem_Data      = data_q;
  assign Words_Written = count_q;

endmodule

// File: tb/tb_i281_instr_encoder_loader.sv
// Self-checking bench for the i281 program loader: directed scenarios plus
// random programs compared against a queue-based reference model.
module tb_i281_instr_encoder_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              Clock = 1'b0;
  logic              Reset_n;
  logic              Start;
  logic              In_Valid;
  logic              In_Ready;
  logic [4:0]        In_Mnem;
  logic [1:0]        In_X;
  logic [1:0]        In_Y;
  logic [7:0]        In_Imm;
  logic              In_Last;
  logic              Mem_WE;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [15:0]       Mem_Data;
  logic [ADDR_W:0]   Words_Written;
  logic              Busy;
  logic              Done;
  logic              Error;

  i281_instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .In_Valid(In_Valid),
    .In_Ready(In_Ready), .In_Mnem(In_Mnem), .In_X(In_X), .In_Y(In_Y),
    .In_Imm(In_Imm), .In_Last(In_Last), .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr),
    .Mem_Data(Mem_Data), .Words_Written(Words_Written), .Busy(Busy),
    .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int m;
    int x;
    int y;
    int imm;
    bit last;
  } item_t;

  typedef struct {
    int a;
    int d;
  } wr_t;

  localparam int M_IDLE = 0, M_ACTIVE = 1, M_DONE = 2, M_ERR = 3;

  item_t prog[$];
  wr_t   exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    mdl_state = M_IDLE;
  int    mdl_cnt = 0;
  int    mdl_last_word = 0;
  int    mdl_last_addr = 0;
  bit    pend_we = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Encoding straight from the ISA table: word = op*4096 + X*1024 + Y*256 + imm
  function automatic int ref_word(input int m, input int x, input int y, input int imm);
    int op, fx, fy, fi;
    op = 0; fx = x; fy = 0; fi = imm;
    if (m == 0) return 0;
    else if (m >= 1 && m <= 4) begin op = 1; fy = m - 1; end
    else if (m == 5 || m == 7 || m == 9 || m == 17) begin
      op = (m == 5) ? 2 : (m == 7) ? 4 : (m == 9) ? 6 : 13;
      fy = y; fi = 0;
    end
    else if (m == 6)  op = 3;
    else if (m == 8)  op = 5;
    else if (m == 10) op = 7;
    else if (m == 11) op = 8;
    else if (m == 13) op = 10;
    else if (m == 12 || m == 14) begin op = (m == 12) ? 9 : 11; fy = y; end
    else if (m == 15 || m == 16) begin op = 12; fy = m - 15; fi = 0; end
    else if (m == 18) begin op = 14; fx = 0; end
    else begin op = 15; fx = 0; fy = m - 19; end
    return op * 4096 + fx * 1024 + fy * 256 + fi;
  endfunction

  always @(negedge Clock) begin
    wr_t e;
    if (Reset_n && Mem_WE) begin
      if (exp_q.size() == 0) chk("unexpected_we", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("mem_addr", int'(Mem_Addr), e.a);
        chk("mem_data", int'(Mem_Data), e.d);
      end
    end
  end

  task automatic add_item(input int m, input int x, input int y, input int imm, input bit last);
    item_t it;
    it.m = m; it.x = x; it.y = y; it.imm = imm; it.last = last;
    prog.push_back(it);
  endtask

  task automatic start_sess();
    @(negedge Clock);
    Start = 1'b1;
    mdl_state = M_ACTIVE; mdl_cnt = 0; mdl_last_addr = 0; pend_we = 0;
    @(negedge Clock);
    Start = 1'b0;
    chk("start_done", int'(Done), 0);
    chk("start_error", int'(Error), 0);
    chk("start_count", int'(Words_Written), 0);
    chk("start_busy", int'(Busy), 1);
    chk("start_addr", int'(Mem_Addr), 0);
  endtask

  // Presents prog items; the model decides what each handshake should do.
  task automatic feed();
    int idx, cyc, extra;
    bit exp_ready;
    idx = 0; cyc = 0; extra = 0;
    forever begin
      @(negedge Clock);
      exp_ready = (mdl_state == M_ACTIVE) && !pend_we;
      if (pend_we) begin
        chk("we_latency", int'(Mem_WE), 1);
        pend_we = 0;
      end
      if (idx >= prog.size()) break;
      if (mdl_state != M_ACTIVE) begin
        extra++;
        if (extra > 3) break;
      end
      cyc++;
      if (cyc > 4 * prog.size() + 20) begin
        chk("feed_budget", 0, 1);
        break;
      end
      In_Valid = 1'b1;
      In_Mnem = 5'(prog[idx].m); In_X = 2'(prog[idx].x); In_Y = 2'(prog[idx].y);
      In_Imm = 8'(prog[idx].imm); In_Last = prog[idx].last;
      chk("in_ready", int'(In_Ready), int'(exp_ready));
      if (In_Ready) begin
        if (mdl_state != M_ACTIVE) chk("accept_after_end", 1, 0);
        else if (prog[idx].m > 22) mdl_state = M_ERR;
        else begin
          wr_t w;
          w.a = mdl_cnt;
          w.d = ref_word(prog[idx].m, prog[idx].x, prog[idx].y, prog[idx].imm);
          exp_q.push_back(w);
          mdl_last_word = w.d; mdl_last_addr = mdl_cnt;
          mdl_cnt++;
          pend_we = 1;
          if (prog[idx].last || mdl_cnt == DEPTH) mdl_state = M_DONE;
        end
        idx++;
      end
    end
    In_Valid = 1'b0;
    prog.delete();
  endtask

  task automatic end_check();
    @(negedge Clock);
    chk("end_done", int'(Done), int'(mdl_state == M_DONE));
    chk("end_error", int'(Error), int'(mdl_state == M_ERR));
    chk("end_busy", int'(Busy), int'(mdl_state == M_ACTIVE));
    chk("end_count", int'(Words_Written), mdl_cnt);
    chk("end_data_hold", int'(Mem_Data), mdl_last_word);
    chk("end_addr_hold", int'(Mem_Addr), mdl_last_addr);
    chk("missing_writes", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    Reset_n = 1'b0; Start = 1'b0; In_Valid = 1'b0; In_Mnem = '0;
    In_X = '0; In_Y = '0; In_Imm = '0; In_Last = 1'b0;
    #3;
    chk("rst_ready", int'(In_Ready), 0);
    chk("rst_we", int'(Mem_WE), 0);
    chk("rst_addr", int'(Mem_Addr), 0);
    chk("rst_data", int'(Mem_Data), 0);
    chk("rst_count", int'(Words_Written), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_error", int'(Error), 0);
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;

    // single ADDI, last
    add_item(8, 2, 0, 8'h05, 1);
    start_sess(); feed(); end_check();
    chk("addi_word", ref_word(8, 2, 0, 5), 32'h5805);

    // three-instruction program
    add_item(4, 3, 0, 8'h10, 0);
    add_item(16, 1, 0, 8'hAA, 0);
    add_item(21, 0, 0, 8'hFC, 1);
    start_sess(); feed(); end_check();

    // memory full: 33 MOVEs, never last
    for (int i = 0; i < 33; i++) add_item(5, 1, 2, 0, 0);
    start_sess(); feed(); end_check();

    // NOOP then illegal code
    add_item(0, 3, 3, 8'hFF, 0);
    add_item(25, 1, 1, 8'h11, 0);
    start_sess(); feed(); end_check();
    add_item(0, 0, 0, 0, 1);
    start_sess(); feed(); end_check();

    // reset during WRITE
    start_sess();
    @(negedge Clock);
    In_Valid = 1'b1; In_Mnem = 5'd7; In_X = 2'd1; In_Y = 2'd3; In_Imm = 8'h00; In_Last = 1'b0;
    chk("rst_mid_ready", int'(In_Ready), 1);
    @(posedge Clock);
    #2;
    chk("rst_mid_we_pre", int'(Mem_WE), 1);
    Reset_n = 1'b0;
    In_Valid = 1'b0;
    #1;
    chk("rst_mid_we", int'(Mem_WE), 0);
    chk("rst_mid_addr", int'(Mem_Addr), 0);
    chk("rst_mid_data", int'(Mem_Data), 0);
    chk("rst_mid_busy", int'(Busy), 0);
    chk("rst_mid_count", int'(Words_Written), 0);
    chk("rst_mid_ready2", int'(In_Ready), 0);
    @(negedge Clock);
    Reset_n = 1'b1;
    mdl_state = M_IDLE; mdl_cnt = 0; mdl_last_word = 0; mdl_last_addr = 0;
    add_item(6, 0, 0, 8'h7F, 1);
    start_sess(); feed(); end_check();

    // Start while in ACCEPT is ignored
    add_item(6, 1, 0, 8'h03, 0);
    start_sess(); feed();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (10) @(negedge Clock);
    chk("ign_start_count", int'(Words_Written), 1);
    chk("ign_start_ready", int'(In_Ready), 1);
    chk("ign_start_busy", int'(Busy), 1);
    add_item(19, 2, 1, 8'h09, 1);
    feed(); end_check();

    // random programs
    for (int s = 0; s < 25; s++) begin
      int len;
      len = int'($urandom_range(1, 40));
      for (int i = 0; i < len; i++) begin
        int m;
        m = ($urandom_range(0, 99) < 4) ? int'($urandom_range(23, 31)) : int'($urandom_range(0, 22));
        add_item(m, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 255)), (i == len - 1) || ($urandom_range(0, 7) == 0));
      end
      start_sess(); feed(); end_check();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
